// File: rtl/serial_rx_engine_if.sv
// Bus between the serial receive engine (slave) and the SCON/SBUF register block (master).
interface serial_rx_engine_if #(
  parameter int DATA_BITS = 8
);
  logic                 serial_br_tick_i;
  logic [1:0]           serial_mode_i;
  logic                 serial_scon5_sm2_i;
  logic                 serial_scon4_ren_i;
  logic                 serial_scon0_ri_i;
  logic                 serial_err_clr_i;
  logic                 serial_rxd_i;
  logic [DATA_BITS-1:0] serial_sbuf_o;
  logic                 serial_rb8_o;
  logic                 serial_load_sbuf_o;
  logic                 serial_scon0_ri_o;
  logic                 serial_overrun_o;
  logic                 serial_frame_err_o;
  logic                 serial_txd_shift_o;
  logic                 serial_txd_oe_o;
  logic                 serial_busy_o;

  modport master (
    output serial_br_tick_i, serial_mode_i, serial_scon5_sm2_i, serial_scon4_ren_i,
           serial_scon0_ri_i, serial_err_clr_i, serial_rxd_i,
    input  serial_sbuf_o, serial_rb8_o, serial_load_sbuf_o, serial_scon0_ri_o,
           serial_overrun_o, serial_frame_err_o, serial_txd_shift_o, serial_txd_oe_o,
           serial_busy_o
  );

  modport slave (
    input  serial_br_tick_i, serial_mode_i, serial_scon5_sm2_i, serial_scon4_ren_i,
           serial_scon0_ri_i, serial_err_clr_i, serial_rxd_i,
    output serial_sbuf_o, serial_rb8_o, serial_load_sbuf_o, serial_scon0_ri_o,
           serial_overrun_o, serial_frame_err_o, serial_txd_shift_o, serial_txd_oe_o,
           serial_busy_o
  );
endinterface

// File: rtl/serial_rx_engine.sv
// Serial receive engine: mode 0 synchronous shift and mode 1/2/3 UART reception with
// 3-sample majority vote, false-start rejection, SM2 filtering, overrun and framing flags.
module serial_rx_engine #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic              serial_clock_i,
  input  logic              serial_reset_i,
  serial_rx_engine_if.slave bus
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_V0   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_V1   = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] CNT_V2   = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS);

  typedef enum logic [2:0] {IDLE, M0_LOW, M0_HIGH, START, DATA, BIT9, STOP, DECIDE} state_t;

  state_t               state_q;
  logic                 rxd_s1_q, rxd_s2_q, rxd_s3_q;
  logic [1:0]           mode_q;
  logic                 sm2_q;
  logic [CW-1:0]        cnt_q;
  logic [BW-1:0]        bit_q;
  logic [1:0]           vote_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 bit9_q, stop_q;
  logic [DATA_BITS-1:0] sbuf_q;
  logic                 rb8_q, load_q, ri_q, ovr_q, ferr_q;
  logic                 txd_shift_q, txd_oe_q;

  logic       falling_d, maj_d, pass_d, ferr_set_d;
  logic [1:0] ones_d;

  always_comb begin
    falling_d  = rxd_s3_q & ~rxd_s2_q;
    ones_d     = vote_q + {1'b0, rxd_s2_q};
    maj_d      = ones_d[1];
    pass_d     = 1'b1;
    case (mode_q)
      2'b00:   pass_d = 1'b1;
      2'b01:   pass_d = ~sm2_q | stop_q;
      default: pass_d = ~sm2_q | bit9_q;
    endcase
    ferr_set_d = (state_q == DECIDE) & bus.serial_scon4_ren_i & (mode_q != 2'b00) & ~stop_q;
  end

  always_ff @(posedge serial_clock_i or posedge serial_reset_i) begin
    if (serial_reset_i) begin
      state_q     <= IDLE;
      rxd_s1_q    <= 1'b1;
      rxd_s2_q    <= 1'b1;
      rxd_s3_q    <= 1'b1;
      mode_q      <= 2'b00;
      sm2_q       <= 1'b0;
      cnt_q       <= '0;
      bit_q       <= '0;
      vote_q      <= '0;
      shift_q     <= '0;
      bit9_q      <= 1'b0;
      stop_q      <= 1'b0;
      sbuf_q      <= '0;
      rb8_q       <= 1'b0;
      load_q      <= 1'b0;
      ri_q        <= 1'b0;
      ovr_q       <= 1'b0;
      ferr_q      <= 1'b0;
      txd_shift_q <= 1'b1;
      txd_oe_q    <= 1'b0;
    end else begin
      rxd_s1_q <= bus.serial_rxd_i;
      rxd_s2_q <= rxd_s1_q;
      rxd_s3_q <= rxd_s2_q;
      load_q   <= 1'b0;
      ri_q     <= 1'b0;
      ovr_q    <= 1'b0;
      ferr_q   <= bus.serial_err_clr_i ? 1'b0 : (ferr_q | ferr_set_d);
      if (!bus.serial_scon4_ren_i) begin
        state_q     <= IDLE;
        txd_shift_q <= 1'b1;
        txd_oe_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            txd_shift_q <= 1'b1;
            txd_oe_q    <= 1'b0;
            if (bus.serial_mode_i == 2'b00) begin
              if (!bus.serial_scon0_ri_i) begin
                state_q     <= M0_LOW;
                txd_oe_q    <= 1'b1;
                txd_shift_q <= 1'b0;
                bit_q       <= '0;
                mode_q      <= bus.serial_mode_i;
                sm2_q       <= bus.serial_scon5_sm2_i;
              end
            end else if (falling_d) begin
              state_q <= START;
              cnt_q   <= '0;
              vote_q  <= '0;
              bit_q   <= '0;
              mode_q  <= bus.serial_mode_i;
              sm2_q   <= bus.serial_scon5_sm2_i;
            end
          end
          M0_LOW: if (bus.serial_br_tick_i) begin
            shift_q     <= {rxd_s2_q, shift_q[DATA_BITS-1:1]};
            bit_q       <= bit_q + 1'b1;
            txd_shift_q <= 1'b1;
            state_q     <= M0_HIGH;
          end
          M0_HIGH: if (bus.serial_br_tick_i) begin
            if (bit_q == BIT_LAST) begin
              state_q <= DECIDE;
            end else begin
              state_q     <= M0_LOW;
              txd_shift_q <= 1'b0;
            end
          end
          START, DATA, BIT9, STOP: if (bus.serial_br_tick_i) begin
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            if (cnt_q == CNT_V0 || cnt_q == CNT_V1) vote_q <= ones_d;
            else if (cnt_q == CNT_LAST)             vote_q <= '0;
            // Bit value is settled on the third sample; the bit boundary follows at CNT_LAST.
            if (cnt_q == CNT_V2) begin
              case (state_q)
                START: if (maj_d) state_q <= IDLE;
                DATA: begin
                  shift_q <= {maj_d, shift_q[DATA_BITS-1:1]};
                  bit_q   <= bit_q + 1'b1;
                end
                BIT9:    bit9_q <= maj_d;
                default: begin
                  stop_q  <= maj_d;
                  state_q <= DECIDE;
                end
              endcase
            end else if (cnt_q == CNT_LAST) begin
              case (state_q)
                START:   state_q <= DATA;
                DATA:    if (bit_q == BIT_LAST) state_q <= mode_q[1] ? BIT9 : STOP;
                BIT9:    state_q <= STOP;
                default: ;
              endcase
            end
          end
          DECIDE: begin
            state_q  <= IDLE;
            txd_oe_q <= 1'b0;
            if (pass_d && !bus.serial_scon0_ri_i) begin
              sbuf_q <= shift_q;
              load_q <= 1'b1;
              ri_q   <= 1'b1;
              if (mode_q == 2'b01) rb8_q <= stop_q;
              else if (mode_q[1])  rb8_q <= bit9_q;
            end else if (pass_d) begin
              ovr_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.serial_sbuf_o      = sbuf_q;
  assign bus.serial_rb8_o       = rb8_q;
  assign bus.serial_load_sbuf_o = load_q;
  assign bus.serial_scon0_ri_o  = ri_q;
  assign bus.serial_overrun_o   = ovr_q;
  assign bus.serial_frame_err_o = ferr_q;
  assign bus.serial_txd_shift_o = txd_shift_q;
  assign bus.serial_txd_oe_o    = txd_oe_q;
  assign bus.serial_busy_o      = (state_q != IDLE);
endmodule

// File: tb/tb_serial_rx_engine.sv
// Randomised bench for serial_rx_engine: frame-level reference model feeds a scoreboard
// that a separate monitor drains on every load/overrun pulse.
module tb_serial_rx_engine;
  localparam int DB       = 8;
  localparam int OS       = 16;
  localparam int TICK_DIV = 2;

  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  serial_rx_engine_if #(.DATA_BITS(DB)) bus ();

  serial_rx_engine #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .serial_clock_i (clk),
    .serial_reset_i (rst),
    .bus            (bus)
  );

  typedef struct {
    bit            ovr;
    logic [DB-1:0] sbuf;
    logic          rb8;
  } ev_t;

  typedef struct {
    string       nm;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  ev_t  exp_q[$];
  chk_t chk_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   clr_req  = 0;
  int   clr_ack  = 0;
  bit   done     = 0;

  // Reference model state: what SBUF/RB8/frame_err/RI should hold between frames.
  logic [DB-1:0] m_sbuf;
  logic          m_rb8;
  logic          m_ferr;
  bit            m_ri;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic want(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_t c;
    c.nm  = nm;
    c.act = act;
    c.exp = exp;
    chk_q.push_back(c);
  endtask

  initial begin : tick_gen
    int cnt;
    cnt = 0;
    bus.serial_br_tick_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cnt = (cnt + 1) % TICK_DIV;
      bus.serial_br_tick_i = (cnt == 0);
    end
  end

  initial begin : monitor
    ev_t  e;
    ev_t  pend_e;
    bit   pend;
    chk_t c;
    pend = 0;
    bus.serial_scon0_ri_i = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("load_sbuf", 32'(bus.serial_sbuf_o), 32'(pend_e.sbuf));
        chk("load_rb8", 32'(bus.serial_rb8_o), 32'(pend_e.rb8));
        pend = 0;
      end
      if (bus.serial_load_sbuf_o || bus.serial_scon0_ri_o)
        chk("ri_with_load", 32'(bus.serial_scon0_ri_o), 32'(bus.serial_load_sbuf_o));
      if (bus.serial_load_sbuf_o || bus.serial_overrun_o) begin
        chk("event_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          if (bus.serial_load_sbuf_o) begin
            chk("event_kind_load", 32'(bus.serial_overrun_o), 32'(e.ovr));
            pend_e = e;
            pend   = 1;
          end else begin
            chk("event_kind_overrun", 32'(bus.serial_overrun_o), 32'(e.ovr));
            chk("overrun_sbuf_kept", 32'(bus.serial_sbuf_o), 32'(e.sbuf));
            chk("overrun_rb8_kept", 32'(bus.serial_rb8_o), 32'(e.rb8));
          end
        end
      end
      while (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        chk(c.nm, c.act, c.exp);
      end
      if (bus.serial_scon0_ri_o) bus.serial_scon0_ri_i = 1'b1;
      if (clr_req != clr_ack) begin
        bus.serial_scon0_ri_i = 1'b0;
        clr_ack = clr_req;
      end
      if (done && !pend) begin
        chk("events_left_over", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got no end of test, expected completion within 90000 cycles");
    $fatal(1, "simulation time limit");
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(negedge clk);
      while (!bus.serial_br_tick_i) @(negedge clk);
    end
  endtask

  task automatic clear_ri();
    clr_req++;
    repeat (2) @(negedge clk);
    m_ri = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < 4000 && exp_q.size() != 0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic snap(input string tag);
    @(negedge clk);
    want({tag, ":sbuf"}, 32'(bus.serial_sbuf_o), 32'(m_sbuf));
    want({tag, ":rb8"}, 32'(bus.serial_rb8_o), 32'(m_rb8));
    want({tag, ":frame_err"}, 32'(bus.serial_frame_err_o), 32'(m_ferr));
    want({tag, ":busy"}, 32'(bus.serial_busy_o), 32'd0);
    want({tag, ":txd_shift"}, 32'(bus.serial_txd_shift_o), 32'd1);
    want({tag, ":txd_oe"}, 32'(bus.serial_txd_oe_o), 32'd0);
    want({tag, ":pulses"}, 32'({bus.serial_load_sbuf_o, bus.serial_scon0_ri_o, bus.serial_overrun_o}), 32'd0);
  endtask

  // Frame-level rules: filter, then load if RI clear, else overrun; bad stop flags an error.
  task automatic expect_frame(input logic [1:0] mode, input logic sm2, input logic [DB-1:0] data,
                              input logic b9, input logic stop);
    ev_t e;
    bit  pass;
    if (mode == 2'd0)      pass = 1;
    else if (mode == 2'd1) pass = !sm2 || stop;
    else                   pass = !sm2 || b9;
    if (pass) begin
      if (!m_ri) begin
        m_sbuf = data;
        if (mode == 2'd1)      m_rb8 = stop;
        else if (mode != 2'd0) m_rb8 = b9;
        m_ri  = 1;
        e.ovr = 0;
      end else begin
        e.ovr = 1;
      end
      e.sbuf = m_sbuf;
      e.rb8  = m_rb8;
      exp_q.push_back(e);
    end
    if (mode != 2'd0 && !stop) m_ferr = 1;
  endtask

  task automatic send_uart(input logic [1:0] mode, input logic sm2, input logic [DB-1:0] data,
                           input logic b9, input logic stop, input bit scramble);
    bus.serial_rxd_i = 1'b0;
    wait_ticks(OS);
    if (scramble) begin
      bus.serial_mode_i      = 2'($urandom_range(1, 3));
      bus.serial_scon5_sm2_i = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < DB; i++) begin
      bus.serial_rxd_i = data[i];
      wait_ticks(OS);
    end
    if (mode[1]) begin
      bus.serial_rxd_i = b9;
      wait_ticks(OS);
    end
    bus.serial_mode_i      = mode;
    bus.serial_scon5_sm2_i = sm2;
    bus.serial_rxd_i       = stop;
    wait_ticks(OS);
    bus.serial_rxd_i = 1'b1;
    wait_ticks(4);
  endtask

  task automatic pulse_err_clr();
    @(negedge clk);
    bus.serial_err_clr_i = 1'b1;
    @(negedge clk);
    bus.serial_err_clr_i = 1'b0;
    m_ferr = 0;
  endtask

  initial begin : stimulus
    logic [DB-1:0] d;
    logic [1:0]    md;
    logic          s2, b9, st, prev, cur;
    int            falls, rises;
    bit            oe_ok;

    rst                    = 1'b1;
    bus.serial_mode_i      = 2'd1;
    bus.serial_scon5_sm2_i = 1'b0;
    bus.serial_scon4_ren_i = 1'b0;
    bus.serial_err_clr_i   = 1'b0;
    bus.serial_rxd_i       = 1'b1;
    m_sbuf = '0;
    m_rb8  = 1'b0;
    m_ferr = 1'b0;
    m_ri   = 0;
    repeat (3) @(negedge clk);
    snap("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Mode 0: data presented after each shift-clock rising edge.
    d = 8'hA5;
    bus.serial_mode_i = 2'd0;
    bus.serial_rxd_i  = d[0];
    expect_frame(2'd0, 1'b0, d, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    bus.serial_scon4_ren_i = 1'b1;
    prev  = 1'b1;
    falls = 0;
    rises = 0;
    oe_ok = 1;
    for (int k = 0; k < 3000 && rises < DB; k++) begin
      @(negedge clk);
      cur = bus.serial_txd_shift_o;
      if (prev && !cur) begin
        falls++;
        if (!bus.serial_txd_oe_o) oe_ok = 0;
      end
      if (!prev && cur) begin
        rises++;
        if (rises < DB) bus.serial_rxd_i = d[rises];
      end
      prev = cur;
    end
    want("m0_low_pulses", 32'(falls), 32'(DB));
    want("m0_high_edges", 32'(rises), 32'(DB));
    want("m0_txd_oe", 32'(oe_ok), 32'd1);
    drain();
    bus.serial_scon4_ren_i = 1'b0;
    bus.serial_rxd_i       = 1'b1;
    snap("mode0_done");

    // Mode 1 clean frame.
    clear_ri();
    bus.serial_mode_i      = 2'd1;
    bus.serial_scon4_ren_i = 1'b1;
    repeat (4) @(negedge clk);
    expect_frame(2'd1, 1'b0, 8'h3C, 1'b0, 1'b1);
    send_uart(2'd1, 1'b0, 8'h3C, 1'b0, 1'b1, 0);
    drain();
    snap("mode1_3c");

    // False start: a 4-tick glitch must not start a frame.
    clear_ri();
    bus.serial_rxd_i = 1'b0;
    wait_ticks(4);
    bus.serial_rxd_i = 1'b1;
    wait_ticks(3 * OS);
    snap("false_start");

    // Mode 3 with SM2: address-bit filter.
    bus.serial_mode_i      = 2'd3;
    bus.serial_scon5_sm2_i = 1'b1;
    expect_frame(2'd3, 1'b1, 8'h12, 1'b0, 1'b1);
    send_uart(2'd3, 1'b1, 8'h12, 1'b0, 1'b1, 0);
    expect_frame(2'd3, 1'b1, 8'h55, 1'b1, 1'b1);
    send_uart(2'd3, 1'b1, 8'h55, 1'b1, 1'b1, 0);
    drain();
    snap("mode3_sm2");

    // Bad stop bit: still loads, error sticky until cleared.
    clear_ri();
    bus.serial_mode_i      = 2'd1;
    bus.serial_scon5_sm2_i = 1'b0;
    expect_frame(2'd1, 1'b0, 8'h99, 1'b0, 1'b0);
    send_uart(2'd1, 1'b0, 8'h99, 1'b0, 1'b0, 0);
    drain();
    snap("stop0_err_set");
    wait_ticks(2 * OS);
    snap("stop0_err_held");
    pulse_err_clr();
    snap("stop0_err_cleared");

    // RI still set from the previous frame: overrun.
    expect_frame(2'd1, 1'b0, 8'h42, 1'b0, 1'b1);
    send_uart(2'd1, 1'b0, 8'h42, 1'b0, 1'b1, 0);
    drain();
    snap("overrun");

    // Random frames with mid-frame mode/SM2 changes that must be ignored.
    for (int r = 0; r < 12; r++) begin
      if ($urandom_range(0, 1) == 1) clear_ri();
      md = 2'($urandom_range(1, 3));
      s2 = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      b9 = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 5) != 0);
      bus.serial_mode_i      = md;
      bus.serial_scon5_sm2_i = s2;
      expect_frame(md, s2, d, b9, st);
      send_uart(md, s2, d, b9, st, 1);
      drain();
    end
    snap("random_end");
    pulse_err_clr();

    // Reset in the middle of the data field.
    clear_ri();
    bus.serial_mode_i      = 2'd1;
    bus.serial_scon5_sm2_i = 1'b0;
    bus.serial_rxd_i       = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 3; i++) begin
      bus.serial_rxd_i = 1'($urandom_range(0, 1));
      wait_ticks(OS);
    end
    @(negedge clk);
    rst    = 1'b1;
    m_sbuf = '0;
    m_rb8  = 1'b0;
    m_ferr = 1'b0;
    snap("reset_mid_frame");
    bus.serial_rxd_i = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_ticks(3 * OS);
    snap("after_reset");

    repeat (4) @(negedge clk);
    done = 1;
  end
endmodule
